// File: rtl/polaris_bus_arbiter.sv
// rtl/polaris_bus_arbiter.sv - two-master (I/D) arbiter for one shared memory port with watchdog
module polaris_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic        dwe_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic [63:0] m_adr_o,
    output logic [63:0] m_dat_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [1:0]  m_siz_o,
    output logic        m_signed_o,
    input  logic        m_ack_i,
    input  logic [63:0] m_dat_i,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       last_d_q, last_d_d;
    logic [7:0] wdog_q, wdog_d;

    logic ireq;
    logic dreq;
    logic in_gnt;
    logic gnt_req;
    logic timeout;

    assign ireq   = |isiz_i;
    assign dreq   = dcyc_i & dstb_i;
    assign in_gnt = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);

    always_comb begin
        gnt_req = 1'b0;
        if (state_q == ST_GNT_I) begin
            gnt_req = ireq;
        end else if (state_q == ST_GNT_D) begin
            gnt_req = dreq;
        end
    end

    // A real ack in the final watchdog cycle wins over the abort.
    assign timeout = in_gnt && !m_ack_i && (wdog_q == WDOG_LIMIT);

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wdog_d   = wdog_q;
        case (state_q)
            ST_IDLE: begin
                wdog_d = 8'd0;
                if (ireq && dreq) begin
                    state_d = last_d_q ? ST_GNT_I : ST_GNT_D;
                end else if (ireq) begin
                    state_d = ST_GNT_I;
                end else if (dreq) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (m_ack_i || timeout) begin
                    state_d  = ST_IDLE;
                    last_d_d = (state_q == ST_GNT_D);
                end else if (!gnt_req) begin
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b1;
            wdog_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wdog_q   <= wdog_d;
        end
    end

    // Outputs are a pure function of the grant state, so reset forces them all low at once.
    always_comb begin
        m_adr_o    = 64'd0;
        m_dat_o    = 64'd0;
        m_we_o     = 1'b0;
        m_cyc_o    = 1'b0;
        m_stb_o    = 1'b0;
        m_siz_o    = 2'b00;
        m_signed_o = 1'b0;
        iack_o     = 1'b0;
        idat_o     = 32'd0;
        dack_o     = 1'b0;
        ddat_o     = 64'd0;
        err_o      = timeout;
        case (state_q)
            ST_GNT_I: begin
                m_adr_o = iadr_i;
                m_siz_o = isiz_i;
                m_cyc_o = ireq & ~timeout;
                m_stb_o = ireq & ~timeout;
                iack_o  = m_ack_i | timeout;
                idat_o  = timeout ? 32'd0 : m_dat_i[31:0];
            end
            ST_GNT_D: begin
                m_adr_o    = dadr_i;
                m_dat_o    = ddat_i;
                m_we_o     = dwe_i;
                m_siz_o    = dsiz_i;
                m_signed_o = dsigned_i;
                m_cyc_o    = dcyc_i & ~timeout;
                m_stb_o    = dstb_i & ~timeout;
                dack_o     = m_ack_i | timeout;
                ddat_o     = timeout ? 64'd0 : m_dat_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// tb/tb_polaris_bus_arbiter.sv - directed and randomized bench for polaris_bus_arbiter
module tb_polaris_bus_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic        dwe_i;
    logic        dcyc_i;
    logic        dstb_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] m_adr_o;
    logic [63:0] m_dat_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [1:0]  m_siz_o;
    logic        m_signed_o;
    logic        m_ack_i;
    logic [63:0] m_dat_i;
    logic        err_o;

    polaris_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
        .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
        .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
        .dack_o(dack_o), .ddat_o(ddat_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_siz_o(m_siz_o),
        .m_signed_o(m_signed_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port (0 none, 1 I, 2 D), cycles held so far, and who won last.
    int owner;
    int age;
    bit last_was_d;

    logic        obs_cyc, obs_iack, obs_dack, obs_err, obs_we;
    logic [31:0] obs_idat;
    logic [63:0] obs_mdat, obs_adr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner      = 0;
        age        = 0;
        last_was_d = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cyc"}, {63'd0, m_cyc_o}, 64'd0);
        chk({tag, "_stb"}, {63'd0, m_stb_o}, 64'd0);
        chk({tag, "_adr"}, m_adr_o, 64'd0);
        chk({tag, "_mdat"}, m_dat_o, 64'd0);
        chk({tag, "_ctl"}, {59'd0, m_we_o, m_siz_o, m_signed_o, err_o}, 64'd0);
        chk({tag, "_acks"}, {62'd0, iack_o, dack_o}, 64'd0);
        chk({tag, "_rdat"}, ddat_o | {32'd0, idat_o}, 64'd0);
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        bit          req, tmo, done;
        logic        e_cyc, e_stb, e_we, e_sgn, e_iack, e_dack;
        logic [1:0]  e_siz;
        logic [31:0] e_idat;
        logic [63:0] e_adr, e_mdat, e_ddat;
        @(negedge clk_i);
        req  = (owner == 1) ? (isiz_i != 2'b00) : (owner == 2) ? (dcyc_i && dstb_i) : 1'b0;
        tmo  = (owner != 0) && !m_ack_i && (age == TO - 1);
        done = m_ack_i || tmo;
        {e_cyc, e_stb, e_we, e_sgn, e_iack, e_dack} = 6'b0;
        e_siz = 2'b00; e_idat = 32'd0; e_adr = 64'd0; e_mdat = 64'd0; e_ddat = 64'd0;
        if (owner == 1) begin
            e_adr  = iadr_i;
            e_siz  = isiz_i;
            e_cyc  = req && !tmo;
            e_stb  = req && !tmo;
            e_iack = done;
            e_idat = tmo ? 32'd0 : m_dat_i[31:0];
        end else if (owner == 2) begin
            e_adr  = dadr_i;
            e_mdat = ddat_i;
            e_we   = dwe_i;
            e_siz  = dsiz_i;
            e_sgn  = dsigned_i;
            e_cyc  = dcyc_i && !tmo;
            e_stb  = dstb_i && !tmo;
            e_dack = done;
            e_ddat = tmo ? 64'd0 : m_dat_i;
        end
        chk("cyc", {63'd0, m_cyc_o}, {63'd0, e_cyc});
        chk("stb", {63'd0, m_stb_o}, {63'd0, e_stb});
        chk("adr", m_adr_o, e_adr);
        chk("mdat", m_dat_o, e_mdat);
        chk("we_siz_sgn", {60'd0, m_we_o, m_siz_o, m_signed_o}, {60'd0, e_we, e_siz, e_sgn});
        chk("iack", {63'd0, iack_o}, {63'd0, e_iack});
        chk("idat", {32'd0, idat_o}, {32'd0, e_idat});
        chk("dack", {63'd0, dack_o}, {63'd0, e_dack});
        chk("ddat", ddat_o, e_ddat);
        chk("err", {63'd0, err_o}, {63'd0, tmo});
        obs_cyc = m_cyc_o; obs_iack = iack_o; obs_dack = dack_o; obs_err = err_o;
        obs_we = m_we_o; obs_idat = idat_o; obs_mdat = m_dat_o; obs_adr = m_adr_o;
        @(posedge clk_i);
        #1;
        if (owner == 0) begin
            age = 0;
            if ((isiz_i != 2'b00) && dcyc_i && dstb_i) owner = last_was_d ? 1 : 2;
            else if (isiz_i != 2'b00)                   owner = 1;
            else if (dcyc_i && dstb_i)                  owner = 2;
        end else if (done) begin
            last_was_d = (owner == 2);
            owner      = 0;
        end else if (!req) begin
            owner = 0;
        end else begin
            age++;
        end
    endtask

    initial begin
        reset_i = 1'b0;
        iadr_i = '0; isiz_i = '0; dadr_i = '0; ddat_i = '0; dwe_i = 1'b0;
        dcyc_i = 1'b0; dstb_i = 1'b0; dsiz_i = '0; dsigned_i = 1'b0;
        m_ack_i = 1'b0; m_dat_i = '0;
        model_reset();
        #3;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b1;

        // Reset mid-GNT_D, then a tie after release goes to I.
        dadr_i = 64'h40; dcyc_i = 1'b1; dstb_i = 1'b1;
        cycle();
        cycle();
        chk("t1_gntd_cyc", {63'd0, obs_cyc}, 64'd1);
        #2 reset_i = 1'b0;
        #1 check_all_zero("t1_async_reset");
        model_reset();
        isiz_i = 2'b10; iadr_i = 64'h80;
        @(posedge clk_i);
        #1 reset_i = 1'b1;

        // Both held, ack in every grant cycle: I,D,I,D with IDLE gaps.
        for (int k = 0; k < 8; k++) begin
            m_ack_i = (owner != 0);
            cycle();
            chk("t3_iack", {63'd0, obs_iack}, {63'd0, (k == 1 || k == 5)});
            chk("t3_dack", {63'd0, obs_dack}, {63'd0, (k == 3 || k == 7)});
        end
        isiz_i = 2'b00; dcyc_i = 1'b0; dstb_i = 1'b0; m_ack_i = 1'b0;
        cycle();

        // Fetch with a 2-cycle slave.
        isiz_i = 2'b10; iadr_i = 64'h100; m_dat_i = 64'h13;
        cycle();
        cycle();
        chk("t2_c1_cyc", {63'd0, obs_cyc}, 64'd1);
        chk("t2_c1_adr", obs_adr, 64'h100);
        m_ack_i = 1'b1;
        cycle();
        chk("t2_c2_cyc", {63'd0, obs_cyc}, 64'd1);
        chk("t2_c2_iack", {63'd0, obs_iack}, 64'd1);
        chk("t2_c2_idat", {32'd0, obs_idat}, 64'h13);
        isiz_i = 2'b00; m_ack_i = 1'b0;
        cycle();
        chk("t2_c3_idle", {63'd0, obs_cyc}, 64'd0);

        // D write on the shared port.
        dadr_i = 64'h2000; ddat_i = 64'hDEADBEEF; dwe_i = 1'b1; dsiz_i = 2'b11;
        dcyc_i = 1'b1; dstb_i = 1'b1;
        cycle();
        m_ack_i = 1'b1;
        cycle();
        chk("t4_we", {63'd0, obs_we}, 64'd1);
        chk("t4_mdat", obs_mdat, 64'hDEADBEEF);
        chk("t4_adr", obs_adr, 64'h2000);
        chk("t4_acks", {62'd0, obs_iack, obs_dack}, 64'd1);
        dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0; m_ack_i = 1'b0;
        cycle();

        // Watchdog abort on the 4th grant cycle, pending I follows after turnaround.
        dcyc_i = 1'b1; dstb_i = 1'b1;
        cycle();
        isiz_i = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t5_pre_abort", {61'd0, obs_cyc, obs_dack, obs_err}, 64'b100);
        end
        cycle();
        chk("t5_abort", {61'd0, obs_cyc, obs_dack, obs_err}, 64'b011);
        dcyc_i = 1'b0; dstb_i = 1'b0;
        cycle();
        chk("t5_turnaround", {63'd0, obs_cyc}, 64'd0);
        m_ack_i = 1'b1;
        cycle();
        chk("t5_i_granted", {62'd0, obs_cyc, obs_iack}, 64'b11);
        isiz_i = 2'b00; m_ack_i = 1'b0;
        cycle();

        // D withdraws in its 2nd grant cycle.
        dcyc_i = 1'b1; dstb_i = 1'b1;
        cycle();
        cycle();
        chk("t6_c1_cyc", {63'd0, obs_cyc}, 64'd1);
        dcyc_i = 1'b0;
        cycle();
        chk("t6_c2_drop", {62'd0, obs_cyc, obs_dack}, 64'd0);
        dcyc_i = 1'b1;
        cycle();
        chk("t6_c3_idle", {63'd0, obs_cyc}, 64'd0);
        m_ack_i = 1'b1;
        cycle();
        chk("t6_c4_regrant", {62'd0, obs_cyc, obs_dack}, 64'b11);
        dcyc_i = 1'b0; dstb_i = 1'b0; m_ack_i = 1'b0;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            isiz_i    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            iadr_i    = {$urandom, $urandom};
            dadr_i    = {$urandom, $urandom};
            ddat_i    = {$urandom, $urandom};
            dwe_i     = 1'($urandom);
            dcyc_i    = ($urandom_range(0, 3) != 0);
            dstb_i    = ($urandom_range(0, 3) != 0);
            dsiz_i    = 2'($urandom);
            dsigned_i = 1'($urandom);
            m_ack_i   = ($urandom_range(0, 9) < 3);
            m_dat_i   = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
